// File: rtl/hamming_pkg.sv
// Shared types, FSM state encoding and the SECDED encode function.
// Used by the encoder engine and the program-2 decoder side.
package hamming_pkg;

  typedef logic [11:1] msg_t;
  typedef logic [15:0] cw_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Layout {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}; p0 gives even overall parity.
  function automatic cw_t hamming_encode(input msg_t d);
    logic p8, p4, p2, p1, p0;
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9]  ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
    return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
  endfunction

endpackage

// File: rtl/hamming_enc_core.sv
// Combinational SECDED encoder: 11-bit message in, 16-bit codeword out.
module hamming_enc_core
  import hamming_pkg::*;
(
  input  msg_t msg,
  output cw_t  cw
);

  assign cw = hamming_encode(msg);

endmodule

// File: rtl/hamming_enc_engine.sv
// Memory-mapped SECDED encoder: reads NUM_MSG messages, writes back codewords.
// Four cycles per message over a single shared byte-wide memory port.
module hamming_enc_engine
  import hamming_pkg::*;
#(
  parameter int unsigned NUM_MSG  = 15,
  parameter int unsigned IN_BASE  = 0,
  parameter int unsigned OUT_BASE = 30,
  parameter int unsigned AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data
);

  localparam int unsigned IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;

  state_t        state;
  logic [IW-1:0] idx;
  logic [7:0]    lo_q;
  cw_t           cw_q;
  cw_t           enc_cw;
  logic [AW-1:0] in_addr;
  logic [AW-1:0] out_addr;

  // Hi byte bits [7:3] are dropped here; only d11..d9 come from it.
  hamming_enc_core u_core (
    .msg ({mem_rd_data[2:0], lo_q}),
    .cw  (enc_cw)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      lo_q  <= '0;
      cw_q  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RD_LO;
            idx   <= '0;
          end
        end
        RD_LO: begin
          lo_q  <= mem_rd_data;
          state <= RD_HI;
        end
        RD_HI: begin
          cw_q  <= enc_cw;
          state <= WR_LO;
        end
        WR_LO: state <= WR_HI;
        WR_HI: begin
          if (idx == IW'(NUM_MSG - 1)) begin
            state <= DONE;
          end else begin
            idx   <= idx + IW'(1);
            state <= RD_LO;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_addr  = AW'(IN_BASE)  + (AW'(idx) << 1);
  assign out_addr = AW'(OUT_BASE) + (AW'(idx) << 1);

  // Port outputs decode straight from state so an async reset clears them at once.
  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state)
      RD_LO: mem_addr = in_addr;
      RD_HI: mem_addr = in_addr + AW'(1);
      WR_LO: begin
        mem_addr    = out_addr;
        mem_wr_en   = 1'b1;
        mem_wr_data = cw_q[7:0];
      end
      WR_HI: begin
        mem_addr    = out_addr + AW'(1);
        mem_wr_en   = 1'b1;
        mem_wr_data = cw_q[15:8];
      end
      default: ;
    endcase
  end

  assign busy = (state == RD_LO) || (state == RD_HI) || (state == WR_LO) || (state == WR_HI);
  assign done = (state == DONE);

endmodule

// File: tb/tb_hamming_enc_engine.sv
// Scoreboard bench for hamming_enc_engine: random and directed messages,
// mid-run start, mid-run reset, and single-bit syndrome checks.
module tb_hamming_enc_engine;

  localparam int unsigned NUM_MSG  = 15;
  localparam int unsigned IN_BASE  = 0;
  localparam int unsigned OUT_BASE = 30;
  localparam int unsigned AW       = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;

  logic [7:0] in_mem  [0:255];
  logic [7:0] out_mem [0:255];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int errors = 0;

  hamming_enc_engine #(
    .NUM_MSG (NUM_MSG),
    .IN_BASE (IN_BASE),
    .OUT_BASE(OUT_BASE),
    .AW      (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_data(mem_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd_data = in_mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en === 1'b1) out_mem[mem_addr] <= mem_wr_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: place data bits at the non-power-of-two positions, then pick each
  // check bit so its coverage group has even parity, then fix overall parity.
  function automatic logic [15:0] ref_encode(input logic [11:1] d);
    logic [15:0] c;
    int unsigned k;
    logic p;
    c = '0;
    k = 1;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[k];
        k++;
      end
    end
    for (int j = 0; j < 4; j++) begin
      p = 1'b0;
      for (int pos = 1; pos < 16; pos++)
        if (((pos >> j) & 1) == 1 && pos != (1 << j)) p ^= c[pos];
      c[1 << j] = p;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [3:0] syndrome(input logic [15:0] c);
    logic [3:0] s;
    s = '0;
    for (int pos = 1; pos < 16; pos++)
      if (c[pos]) s ^= 4'(pos);
    return s;
  endfunction

  always @(negedge clk) begin
    if (mem_wr_en !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write", {16'h0, mem_addr, mem_wr_data}, {16'h0, e.addr, e.data});
      end
    end
  end

  task automatic fill_random();
    for (int i = 0; i < 2 * NUM_MSG; i++) in_mem[IN_BASE + i] = 8'($urandom);
  endtask

  task automatic push_run(input int n);
    logic [11:1] m;
    logic [15:0] c;
    wr_t e;
    for (int i = 0; i < n; i++) begin
      m = {in_mem[IN_BASE + 2*i + 1][2:0], in_mem[IN_BASE + 2*i]};
      c = ref_encode(m);
      e.addr = 8'(OUT_BASE + 2*i);     e.data = c[7:0];  exp_q.push_back(e);
      e.addr = 8'(OUT_BASE + 2*i + 1); e.data = c[15:8]; exp_q.push_back(e);
    end
  endtask

  task automatic start_pulse();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_and_wait(input int mid_start);
    int cnt;
    start_pulse();
    chk("busy_after_start", {31'h0, busy}, 32'h1);
    chk("done_after_start", {31'h0, done}, 32'h0);
    cnt = 0;
    while (done !== 1'b1 && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
      start = (cnt == mid_start) ? 1'b1 : 1'b0;
      if (cnt < 60 && (busy !== 1'b1 || done !== 1'b0)) begin
        checks++;
        errors++;
        $display("FAIL busy_done_in_run: got busy %b done %b expected busy 1 done 0", busy, done);
      end
    end
    start = 1'b0;
    chk("done_latency", 32'(cnt), 32'd60);
    chk("busy_at_done", {31'h0, busy}, 32'h0);
    chk("pending_writes", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},    {31'h0, busy},      32'h0);
    chk({tag, "_done"},    {31'h0, done},      32'h0);
    chk({tag, "_wr_en"},   {31'h0, mem_wr_en}, 32'h0);
    chk({tag, "_addr"},    {24'h0, mem_addr},  32'h0);
    chk({tag, "_wr_data"}, {24'h0, mem_wr_data}, 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cw, f;
    logic [15:0] exp_cw [0:4];
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_reset_outputs("por");
    reset = 1'b0;

    // Directed vectors in slots 0..4, random elsewhere.
    fill_random();
    in_mem[0] = 8'h00; in_mem[1] = 8'h00;
    in_mem[2] = 8'hFF; in_mem[3] = 8'h07;
    in_mem[4] = 8'h01; in_mem[5] = 8'h00;
    in_mem[6] = 8'h00; in_mem[7] = 8'h04;
    in_mem[8] = 8'h00; in_mem[9] = 8'hF8;
    exp_cw[0] = 16'h0000; exp_cw[1] = 16'hFFFF; exp_cw[2] = 16'h000F;
    exp_cw[3] = 16'h8117; exp_cw[4] = 16'h0000;
    push_run(NUM_MSG);
    run_and_wait(0);
    for (int i = 0; i < 5; i++)
      chk("directed_cw", {16'h0, out_mem[OUT_BASE + 2*i + 1], out_mem[OUT_BASE + 2*i]}, {16'h0, exp_cw[i]});

    // Random run plus single-bit-flip syndrome checks on the written codewords.
    fill_random();
    push_run(NUM_MSG);
    run_and_wait(0);
    for (int i = 0; i < NUM_MSG; i++) begin
      cw = {out_mem[OUT_BASE + 2*i + 1], out_mem[OUT_BASE + 2*i]};
      chk("clean_syndrome", {27'h0, syndrome(cw), ^cw}, 32'h0);
      for (int b = 0; b < 16; b++) begin
        f = cw ^ (16'h1 << b);
        chk("flip_syndrome", {27'h0, syndrome(f), ^f}, {27'h0, 4'(b), 1'b1});
      end
    end

    // start mid-run must be ignored.
    fill_random();
    push_run(NUM_MSG);
    run_and_wait(23);

    // Reset during cycle 10: only messages 0 and 1 reach memory.
    fill_random();
    push_run(2);
    start_pulse();
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1 chk_reset_outputs("abort");
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_pending", 32'(exp_q.size()), 32'h0);
    chk("abort_idle_busy", {31'h0, busy}, 32'h0);
    chk("abort_idle_done", {31'h0, done}, 32'h0);

    // Full clean run after the abort.
    fill_random();
    push_run(NUM_MSG);
    run_and_wait(0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
